actuated_phase_scheduler: RTL

Demand-driven phase scheduler for the two-direction (NS/EW) intersection. It replaces the fixed-rotation cycle with arbitration between vehicle-detector and pedestrian-button requesters. Green is held in the resting direction until the other direction calls, is extended while own traffic is present, and is capped at a maximum. It drives the same per-direction red/amber/green lamp set plus walk lamps, and is timed by the shared tick enable.

---
 rtl/traffic_pkg.sv | 16 +
 rtl/call_latch.sv | 30 +++
 rtl/actuated_phase_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controllers: phase encodings,
// direction codes and the phase counter width.
package traffic_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_GREEN   = 2'd0,
    S_AMBER   = 2'd1,
    S_ALL_RED = 2'd2
  } phase_e;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

endpackage

// File: rtl/call_latch.sv
// Two-bit set/clear request latch. A clear in the same cycle as a set wins,
// so a call served on this edge is not re-latched by its own button press.
module call_latch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] set_i,
  input  logic [1:0] clr_i,
  output logic [1:0] q_o
);

  logic [1:0] q_q;
  logic [1:0] q_d;

  // Accumulate calls, drop the ones being served this cycle.
  always_comb begin
    q_d = (q_q | set_i) & ~clr_i;
  end

  // Latch register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/actuated_phase_scheduler.sv
// Demand-driven two-direction phase scheduler. Green rests in the served
// direction until the other side calls, is extended by own traffic up to a
// cap, and serves latched pedestrian calls with a walk interval at entry.
module actuated_phase_scheduler #(
  parameter int unsigned T_MIN_GREEN = 5,
  parameter int unsigned T_MAX_GREEN = 20,
  parameter int unsigned T_AMBER     = 3,
  parameter int unsigned T_ALL_RED   = 1,
  parameter int unsigned T_WALK      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [1:0] veh_req,
  input  logic [1:0] ped_req,
  output logic       ns_red,
  output logic       ns_amber,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_amber,
  output logic       ew_green,
  output logic       ns_walk,
  output logic       ew_walk,
  output logic [1:0] ped_pending,
  output logic [1:0] state,
  output logic       dir
);

  import traffic_pkg::*;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_G     = CNT_W'(T_MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_G     = CNT_W'(T_MAX_GREEN);
  localparam logic [CNT_W-1:0] AMB_LAST  = CNT_W'(T_AMBER - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(T_WALK - 1);

  phase_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] walk_cnt_q, walk_cnt_d;
  logic             walk_q, walk_d;
  logic [1:0]       ped_clr;
  logic [1:0]       ped_pend;
  logic             other_call;
  logic             green_exit;

  call_latch u_ped_latch (
    .clk   (clk),
    .rst_n (rst_n),
    .set_i (ped_req),
    .clr_i (ped_clr),
    .q_o   (ped_pend)
  );

  // Phase, direction, counters and walk state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_GREEN;
      dir_q      <= DIR_NS;
      cnt_q      <= '0;
      walk_cnt_q <= '0;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      walk_cnt_q <= walk_cnt_d;
      walk_q     <= walk_d;
    end
  end

  // Next phase, counter updates and pedestrian service at green entry.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    walk_cnt_d = walk_cnt_q;
    walk_d     = walk_q;
    ped_clr    = '0;
    other_call = veh_req[~dir_q] | ped_pend[~dir_q];
    green_exit = other_call && (cnt_q >= MIN_G) && !walk_q &&
                 (!veh_req[dir_q] || (cnt_q >= MAX_G));
    case (state_q)
      S_GREEN: begin
        if (green_exit) begin
          state_d = S_AMBER;
          cnt_d   = '0;
        end else if (tick && (cnt_q < MAX_G)) begin
          cnt_d = cnt_q + ONE;
        end
        if (walk_q && tick) begin
          if (walk_cnt_q == WALK_LAST) begin
            walk_d     = 1'b0;
            walk_cnt_d = '0;
          end else begin
            walk_cnt_d = walk_cnt_q + ONE;
          end
        end
      end
      S_AMBER: begin
        if (tick) begin
          if (cnt_q == AMB_LAST) begin
            state_d = S_ALL_RED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_ALL_RED: begin
        if (tick) begin
          if (cnt_q == AR_LAST) begin
            // Green entry for the opposite side: the walk decision and the
            // latch clear both look at the direction being entered, and the
            // live button is included so a same-edge press is served now.
            state_d    = S_GREEN;
            dir_d      = ~dir_q;
            cnt_d      = '0;
            walk_cnt_d = '0;
            walk_d     = ped_pend[~dir_q] | ped_req[~dir_q];
            ped_clr[~dir_q] = ped_pend[~dir_q] | ped_req[~dir_q];
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      default: begin
        state_d    = S_GREEN;
        dir_d      = DIR_NS;
        cnt_d      = '0;
        walk_cnt_d = '0;
        walk_d     = 1'b0;
      end
    endcase
  end

  // Lamp, walk and debug outputs decoded from registered state only.
  always_comb begin
    ns_green    = (state_q == S_GREEN) && (dir_q == DIR_NS);
    ns_amber    = (state_q == S_AMBER) && (dir_q == DIR_NS);
    ew_green    = (state_q == S_GREEN) && (dir_q == DIR_EW);
    ew_amber    = (state_q == S_AMBER) && (dir_q == DIR_EW);
    ns_red      = !(ns_green || ns_amber);
    ew_red      = !(ew_green || ew_amber);
    ns_walk     = walk_q && ns_green;
    ew_walk     = walk_q && ew_green;
    ped_pending = ped_pend;
    state       = state_q;
    dir         = dir_q;
  end

endmodule
